fib_stream_gen: RTL and testbench

- Parametrised, restartable Fibonacci/Lucas sequence generator.
- Emits a programmable number of terms over a valid/ready stream with backpressure.
- Saturates on overflow and flags it, per term and sticky.
- Feeds downstream datapath/test-pattern consumers in place of the fixed-width, free-running, unhandshaked generator used so far.

---
 rtl/fib_stream_gen.sv | 134 +++++++++++++
 tb/tb_fib_stream_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_stream_gen.sv
// Restartable Fibonacci/Lucas term generator with a valid/ready output stream.
// Terms saturate at all-ones once the unsigned sum no longer fits in WIDTH bits.
module fib_stream_gen #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] n_terms,
    input  logic             mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             out_sat,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sat_a_q, sat_a_d;
    logic             sat_b_q, sat_b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum_c;

    // One extra bit so the carry out of the term width is visible.
    assign sum_c = {1'b0, a_q} + {1'b0, b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sat_a_q <= 1'b0;
            sat_b_q <= 1'b0;
            idx_q   <= '0;
            n_q     <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sat_a_q <= sat_a_d;
            sat_b_q <= sat_b_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sat_a_d = sat_a_q;
        sat_b_d = sat_b_q;
        idx_d   = idx_q;
        n_d     = n_q;
        last_d  = last_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (n_terms == '0) begin
                        done_d = 1'b1;
                    end else begin
                        n_d     = n_terms;
                        a_d     = mode ? WIDTH'(2) : '0;
                        b_d     = WIDTH'(1);
                        sat_a_d = 1'b0;
                        sat_b_d = 1'b0;
                        idx_d   = '0;
                        last_d  = (n_terms == IDX_W'(1));
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        a_d     = b_q;
                        sat_a_d = sat_b_q;
                        idx_d   = idx_q + IDX_W'(1);
                        last_d  = ((idx_q + IDX_W'(1)) == (n_q - IDX_W'(1)));
                        // Saturation is sticky: a saturated operand keeps every later term pinned.
                        if (sum_c[WIDTH] || sat_a_q || sat_b_q) begin
                            b_d     = '1;
                            sat_b_d = 1'b1;
                        end else begin
                            b_d = sum_c[WIDTH-1:0];
                        end
                        ovf_d = ovf_q | sat_b_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign out_data  = a_q;
    assign out_index = idx_q;
    assign out_last  = last_q;
    assign out_sat   = sat_a_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Directed bench for fib_stream_gen: a 32-bit and an 8-bit instance share stimulus.
module tb_fib_stream_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] n_terms;
    logic       mode;
    logic       out_ready;

    logic        v32, l32, s32, b32, dn32, o32;
    logic [31:0] d32;
    logic [7:0]  x32;
    logic        v8, l8, s8, b8, dn8, o8;
    logic [7:0]  d8;
    logic [7:0]  x8;

    int checks = 0;
    int errors = 0;

    int unsigned fib10[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    int unsigned luc6[6]   = '{2, 1, 3, 4, 7, 11};
    int unsigned fib8[17]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 255, 255, 255};

    fib_stream_gen #(.WIDTH(32), .IDX_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms), .mode(mode),
        .out_ready(out_ready), .out_valid(v32), .out_data(d32), .out_index(x32),
        .out_last(l32), .out_sat(s32), .busy(b32), .done(dn32), .overflow(o32)
    );

    fib_stream_gen #(.WIDTH(8), .IDX_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms), .mode(mode),
        .out_ready(out_ready), .out_valid(v8), .out_data(d8), .out_index(x8),
        .out_last(l8), .out_sat(s8), .busy(b8), .done(dn8), .overflow(o8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; n_terms = '0; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({v32, d32, x32, l32, s32, b32, dn32, o32} !== 46'd0) begin
            errors++;
            $display("FAIL reset32: got %h expected 0", {v32, d32, x32, l32, s32, b32, dn32, o32});
        end
        checks++;
        if ({v8, d8, x8, l8, s8, b8, dn8, o8} !== 22'd0) begin
            errors++;
            $display("FAIL reset8: got %h expected 0", {v8, d8, x8, l8, s8, b8, dn8, o8});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fib10();
        start = 1'b1; n_terms = 8'd10; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({v32, d32, x32, l32, s32, o32} !== {1'b1, fib10[i], 8'(i), (i == 9), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL fib10[%0d]: got data %0d idx %0d last %b valid %b, expected data %0d idx %0d",
                         i, d32, x32, l32, v32, fib10[i], i);
            end
            @(negedge clk);
        end
        checks++;
        if ({v32, b32, dn32, o32} !== 4'b0010) begin
            errors++;
            $display("FAIL fib10_done: got v/busy/done/ovf %b expected 0010", {v32, b32, dn32, o32});
        end
        @(negedge clk);
        checks++;
        if (dn32 !== 1'b0) begin
            errors++;
            $display("FAIL fib10_done_width: got done %b expected 0", dn32);
        end
    endtask

    task automatic test_lucas();
        int busy_cycles;
        busy_cycles = 0;
        start = 1'b1; n_terms = 8'd6; mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (b32) busy_cycles++;
            if (i < 6) begin
                checks++;
                if ({v32, d32, x32, l32} !== {1'b1, luc6[i], 8'(i), (i == 5)}) begin
                    errors++;
                    $display("FAIL lucas[%0d]: got data %0d idx %0d last %b expected data %0d idx %0d",
                             i, d32, x32, l32, luc6[i], i);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (busy_cycles != 6) begin
            errors++;
            $display("FAIL lucas_busy: got %0d busy cycles expected 6", busy_cycles);
        end
    endtask

    task automatic test_saturation();
        start = 1'b1; n_terms = 8'd17; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if ({v8, d8, x8, s8, o8, l8} !== {1'b1, 8'(fib8[i]), 8'(i), (i >= 14), (i >= 14), (i == 16)}) begin
                errors++;
                $display("FAIL sat8[%0d]: got data %0d sat %b ovf %b last %b expected data %0d sat %b",
                         i, d8, s8, o8, l8, fib8[i], (i >= 14));
            end
            @(negedge clk);
        end
        checks++;
        if ({v8, dn8, o8} !== 3'b011) begin
            errors++;
            $display("FAIL sat8_after_done: got v/done/ovf %b expected 011", {v8, dn8, o8});
        end
        start = 1'b1; n_terms = 8'd3;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({v8, d8, x8, s8, o8} !== {1'b1, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sat8_restart: got data %0d sat %b ovf %b expected 0 0 0", d8, s8, o8);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int unsigned exp8[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
        start = 1'b1; n_terms = 8'd8; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if ({v32, d32, x32, l32} !== {1'b1, 32'd3, 8'd4, 1'b0}) begin
                        errors++;
                        $display("FAIL bp_hold[%0d]: got data %0d idx %0d valid %b expected 3 4 1", k, d32, x32, v32);
                    end
                end
                out_ready = 1'b1;
            end
            checks++;
            if ({v32, d32, x32, l32} !== {1'b1, exp8[i], 8'(i), (i == 7)}) begin
                errors++;
                $display("FAIL bp[%0d]: got data %0d idx %0d last %b expected data %0d idx %0d",
                         i, d32, x32, l32, exp8[i], i);
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_and_ignored_start();
        start = 1'b1; n_terms = 8'd0; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({v32, b32, dn32} !== 3'b001) begin
            errors++;
            $display("FAIL zero_terms: got v/busy/done %b expected 001", {v32, b32, dn32});
        end
        @(negedge clk);
        start = 1'b1; n_terms = 8'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; n_terms = 8'd3; mode = 1'b1;
            end else begin
                start = 1'b0;
            end
            checks++;
            if ({v32, d32, x32, l32} !== {1'b1, fib10[i], 8'(i), (i == 4)}) begin
                errors++;
                $display("FAIL start_in_run[%0d]: got data %0d idx %0d last %b expected data %0d idx %0d",
                         i, d32, x32, l32, fib10[i], i);
            end
            @(negedge clk);
        end
        start = 1'b0; mode = 1'b0;
        checks++;
        if ({v32, dn32} !== 2'b01) begin
            errors++;
            $display("FAIL start_in_run_end: got v/done %b expected 01", {v32, dn32});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        start = 1'b1; n_terms = 8'd2; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({v32, dn32} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gap: got v/done %b expected 01", {v32, dn32});
        end
        start = 1'b1; n_terms = 8'd2; mode = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        checks++;
        if ({v32, d32, x32} !== {1'b1, 32'd2, 8'd0}) begin
            errors++;
            $display("FAIL b2b_restart: got v %b data %0d idx %0d expected 1 2 0", v32, d32, x32);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        start = 1'b1; n_terms = 8'd8; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({v32, x32} !== {1'b1, 8'd3}) begin
            errors++;
            $display("FAIL arst_pre: got v %b idx %0d expected 1 3", v32, x32);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({v32, b32, dn32, x32} !== 11'd0) begin
            errors++;
            $display("FAIL arst_async: got v/busy/done/idx %h expected 0", {v32, b32, dn32, x32});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({v32, dn32} !== 2'b00) begin
                errors++;
                $display("FAIL arst_no_done[%0d]: got v/done %b expected 00", k, {v32, dn32});
            end
        end
        start = 1'b1; n_terms = 8'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({v32, d32, x32} !== {1'b1, 32'd0, 8'd0}) begin
            errors++;
            $display("FAIL arst_fresh: got v %b data %0d idx %0d expected 1 0 0", v32, d32, x32);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fib10();
        test_lucas();
        test_saturation();
        test_backpressure();
        test_zero_and_ignored_start();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
